qpsk_symbol_sequencer: RTL and testbench
========================================

QPSK_SYMBOL_SEQUENCER -- requirements
Module: qpsk_symbol_sequencer

Interface
REQ-001 SHALL have parameter SPS, default 100: samples per symbol, equal to the sine table depth.
REQ-002 SHALL have port Clk, input, 1: sole clock; all logic on rising edge.
REQ-003 SHALL have port Rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: single-cycle request to begin modulation.
REQ-005 SHALL have port stop, input, 1: single-cycle request to end after the current symbol.
REQ-006 SHALL have ports bit_in (input, 1) and bit_valid (input, 1): serial data bit, qualified by bit_valid.
REQ-007 SHALL have port bit_ready, output, 1: a bit is accepted on an edge where bit_valid & bit_ready.
REQ-008 SHALL have port phase_idx, output, 7: sine table address, 0..SPS-1.
REQ-009 SHALL have ports sample_valid (output, 1) and sym_strobe (output, 1): phase_idx is meaningful; first sample of a symbol.
REQ-010 SHALL have ports E and O, output, 1 each: even/odd bits of the current symbol.
REQ-011 SHALL have ports busy (output, 1) and underrun (output, 1): state != IDLE; sticky starvation flag.

Function
REQ-012 SHALL implement states IDLE, FILL, RUN.
REQ-013 SHALL assemble bit pairs: first accepted bit = E, second = O. Half register holds E; a completed pair goes to a one-deep pending-symbol register.
REQ-014 SHALL drive bit_ready = ~(half_full & pend_full) in FILL and RUN, and 0 in IDLE.
REQ-015 SHALL, in IDLE, go to FILL on start. start while busy is ignored.
REQ-016 SHALL, in FILL, go to RUN on the edge after pending becomes full, loading pending into the current symbol.
REQ-017 SHALL, in RUN, use a sample counter s in 0..SPS-1 and register phase_idx = (offset + s) mod SPS.
REQ-018 SHALL derive phase_idx by compare-and-subtract only, with no divider.
REQ-019 SHALL use offsets {O,E}: 00->0, 01->25, 10->50, 11->75.
REQ-020 SHALL assert sym_strobe for exactly the s==0 cycle. sample_valid SHALL be 1 throughout RUN.
REQ-021 SHALL update E and O only at s==0 and hold them for the full symbol.
REQ-022 SHALL treat the edge leaving s==SPS-1 as the symbol boundary, with the following rules:
- pending full: load it, s <- 0, pending cleared.
- pair completing on the boundary edge: bypasses into current; counts as available.
- pending empty: underrun <- 1 (sticky until Rst), go to IDLE.
- stop_req set: go to IDLE; discard half and pending. stop takes precedence over underrun; underrun is not set.
REQ-023 SHALL register a stop pulse in RUN or FILL into stop_req. stop in FILL SHALL go to IDLE on the next edge.
REQ-024 SHALL produce first sample latency of exactly 1 cycle: the pair completes on edge N, and edge N+1 shows sym_strobe=1 with phase_idx=offset.
REQ-025 SHALL, in IDLE, drive phase_idx=0, sample_valid=0, sym_strobe=0, and hold E and O.

Reset
REQ-026 SHALL, on Rst=1 at an edge in any state, set state=IDLE, phase_idx=0, s=0, E=0, O=0, sample_valid=0, sym_strobe=0, busy=0, underrun=0, bit_ready=0, and clear half, pending and stop_req.
REQ-027 SHALL take Rst over start, stop and bit_valid on the same edge. A mid-symbol reset SHALL abort with no further samples.

Configuration
REQ-028 SHALL, with QPSK_GRAY_MAP_EN defined, use Gray offsets {O,E}: 00->0, 01->25, 11->50, 10->75.
REQ-029 SHALL, with QPSK_GRAY_MAP_EN undefined, use the REQ-019 natural mapping. No other behaviour SHALL differ.

Verification
REQ-030 SHALL cover: Rst, start, bits 1,0 -> E=1, O=0; next cycle sym_strobe=1, phase_idx=25, then 26..99, 0..24, over 100 cycles.
REQ-031 SHALL cover: bits 1,1, then 0,1 supplied early -> phase_idx 75.., then at the boundary sym_strobe with phase_idx=50 (natural) or 75 (QPSK_GRAY_MAP_EN); no gap in sample_valid.
REQ-032 SHALL cover: one symbol only, no further bits -> after 100 samples underrun=1, busy=0, phase_idx=0; underrun stays 1 until Rst.
REQ-033 SHALL cover: pending full and half full -> bit_ready=0; bit_valid held is not accepted until the boundary frees pending.
REQ-034 SHALL cover: stop at s=40 with pending full -> samples continue to s=99, then IDLE, underrun=0, and pending discarded (next start needs new bits).
REQ-035 SHALL cover: Rst asserted at s=60 -> next cycle all REQ-026 values; start with fresh bits restarts correctly.

Source files
------------

// File: rtl/qpsk_symbol_sequencer.sv
// QPSK symbol sequencer: packs serial bits into {E,O} pairs and walks a sine-table
// phase index per symbol. Optional Gray offset mapping with `QPSK_GRAY_MAP_EN.
module qpsk_symbol_sequencer #(
  parameter int SPS = 100
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       start,
  input  logic       stop,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic [6:0] phase_idx,
  output logic       sample_valid,
  output logic       sym_strobe,
  output logic       E,
  output logic       O,
  output logic       busy,
  output logic       underrun
);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  localparam logic [6:0] LAST = 7'(SPS - 1);
  localparam logic [6:0] QTR1 = 7'(SPS / 4);
  localparam logic [6:0] QTR2 = 7'(SPS / 2);
  localparam logic [6:0] QTR3 = 7'((3 * SPS) / 4);

  state_t     state;
  logic [6:0] s;
  logic       half_full;
  logic       half_e;
  logic       pend_full;
  logic       pend_e;
  logic       pend_o;
  logic       stop_req;
  logic       accept;
  logic       pair_done;

  function automatic logic [6:0] sym_offset(input logic o, input logic e);
    logic [6:0] off;
`ifdef QPSK_GRAY_MAP_EN
    case ({o, e})
      2'b00:   off = 7'd0;
      2'b01:   off = QTR1;
      2'b11:   off = QTR2;
      default: off = QTR3;
    endcase
`else
    case ({o, e})
      2'b00:   off = 7'd0;
      2'b01:   off = QTR1;
      2'b10:   off = QTR2;
      default: off = QTR3;
    endcase
`endif
    return off;
  endfunction

  // Wraps with a compare rather than a modulo so no divider is inferred.
  function automatic logic [6:0] next_phase(input logic [6:0] p);
    return (p == LAST) ? 7'd0 : p + 7'd1;
  endfunction

  assign bit_ready    = (state != IDLE) && !(half_full && pend_full);
  assign accept       = bit_valid && bit_ready;
  assign pair_done    = accept && half_full;
  assign busy         = (state != IDLE);
  assign sample_valid = (state == RUN);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      s          <= 7'd0;
      phase_idx  <= 7'd0;
      sym_strobe <= 1'b0;
      E          <= 1'b0;
      O          <= 1'b0;
      underrun   <= 1'b0;
      half_full  <= 1'b0;
      half_e     <= 1'b0;
      pend_full  <= 1'b0;
      pend_e     <= 1'b0;
      pend_o     <= 1'b0;
      stop_req   <= 1'b0;
    end else begin
      // Bit pairing; later assignments below override when a symbol consumes or discards.
      if (accept) begin
        if (!half_full) begin
          half_full <= 1'b1;
          half_e    <= bit_in;
        end else begin
          half_full <= 1'b0;
          pend_full <= 1'b1;
          pend_e    <= half_e;
          pend_o    <= bit_in;
        end
      end
      sym_strobe <= 1'b0;

      case (state)
        IDLE: begin
          phase_idx <= 7'd0;
          s         <= 7'd0;
          if (start) state <= FILL;
        end

        FILL: begin
          if (stop) begin
            state     <= IDLE;
            half_full <= 1'b0;
            pend_full <= 1'b0;
            stop_req  <= 1'b0;
          end else if (pend_full) begin
            state      <= RUN;
            E          <= pend_e;
            O          <= pend_o;
            phase_idx  <= sym_offset(pend_o, pend_e);
            s          <= 7'd0;
            sym_strobe <= 1'b1;
            pend_full  <= 1'b0;
          end
        end

        RUN: begin
          if (stop) stop_req <= 1'b1;
          if (s != LAST) begin
            s         <= s + 7'd1;
            phase_idx <= next_phase(phase_idx);
          end else if (stop_req) begin
            state     <= IDLE;
            s         <= 7'd0;
            phase_idx <= 7'd0;
            half_full <= 1'b0;
            pend_full <= 1'b0;
            stop_req  <= 1'b0;
          end else if (pend_full) begin
            E          <= pend_e;
            O          <= pend_o;
            phase_idx  <= sym_offset(pend_o, pend_e);
            s          <= 7'd0;
            sym_strobe <= 1'b1;
            pend_full  <= 1'b0;
          end else if (pair_done) begin
            // Pair finishing on the boundary skips pending and goes straight to current.
            E          <= half_e;
            O          <= bit_in;
            phase_idx  <= sym_offset(bit_in, half_e);
            s          <= 7'd0;
            sym_strobe <= 1'b1;
            pend_full  <= 1'b0;
          end else begin
            underrun  <= 1'b1;
            state     <= IDLE;
            s         <= 7'd0;
            phase_idx <= 7'd0;
            half_full <= 1'b0;
            stop_req  <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qpsk_symbol_sequencer.sv
// Directed bench for qpsk_symbol_sequencer (SPS=100): a vector table for the
// start-up path plus hand-written long sequences for boundaries, stop and reset.
module tb_qpsk_symbol_sequencer;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_ready;
  logic [6:0] phase_idx;
  logic       sample_valid;
  logic       sym_strobe;
  logic       E;
  logic       O;
  logic       busy;
  logic       underrun;

  int vectors = 0;
  int fails   = 0;

  qpsk_symbol_sequencer #(.SPS(100)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .stop(stop),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .phase_idx(phase_idx), .sample_valid(sample_valid), .sym_strobe(sym_strobe),
    .E(E), .O(O), .busy(busy), .underrun(underrun)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst, st, sp, bv, bi;
    logic       rdy, sv, ss, e, o, bsy, ur;
    logic [6:0] ph;
  } vec_t;

  function automatic logic [6:0] exp_off(input logic o, input logic e);
`ifdef QPSK_GRAY_MAP_EN
    case ({o, e})
      2'b00:   return 7'd0;
      2'b01:   return 7'd25;
      2'b11:   return 7'd50;
      default: return 7'd75;
    endcase
`else
    case ({o, e})
      2'b00:   return 7'd0;
      2'b01:   return 7'd25;
      2'b10:   return 7'd50;
      default: return 7'd75;
    endcase
`endif
  endfunction

  task automatic step(input logic r, input logic st, input logic sp,
                      input logic bv, input logic bi);
    @(negedge Clk);
    Rst = r; start = st; stop = sp; bit_valid = bv; bit_in = bi;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic rdy, input logic sv,
                       input logic ss, input logic e, input logic o,
                       input logic bsy, input logic ur, input logic [6:0] ph);
    vectors++;
    if ({bit_ready, sample_valid, sym_strobe, E, O, busy, underrun, phase_idx} !==
        {rdy, sv, ss, e, o, bsy, ur, ph}) begin
      fails++;
      $display("FAIL %s: got rdy=%b sv=%b ss=%b E=%b O=%b busy=%b ur=%b ph=%0d, want rdy=%b sv=%b ss=%b E=%b O=%b busy=%b ur=%b ph=%0d",
               name, bit_ready, sample_valid, sym_strobe, E, O, busy, underrun, phase_idx,
               rdy, sv, ss, e, o, bsy, ur, ph);
    end
  endtask

  vec_t tbl [6];
  logic [6:0] off2;

  initial begin
    // rst st sp bv bi | rdy sv ss E O busy ur ph
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'd25};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'd26};

    for (int i = 0; i < 6; i++) begin
      step(tbl[i].rst, tbl[i].st, tbl[i].sp, tbl[i].bv, tbl[i].bi);
      check($sformatf("tbl%0d", i), tbl[i].rdy, tbl[i].sv, tbl[i].ss, tbl[i].e,
            tbl[i].o, tbl[i].bsy, tbl[i].ur, tbl[i].ph);
    end

    // Symbol 10 runs to completion with no further bits, then starves.
    for (int k = 2; k < 100; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("runA_s%0d", k), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
            7'((25 + k) % 100));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("underrun_set", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'd0);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("underrun_hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'd0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("underrun_sticky_fill", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 7'd0);

    // Back-to-back symbols 11 then 10 with early bits and a held bit_valid.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rstB", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("fillB", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("firstB", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 7'd75);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("runB_s1_start_ignored", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7'd76);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("runB_s2_pend", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7'd77);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("runB_s3_full", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7'd78);
    for (int k = 4; k < 100; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check($sformatf("runB_held_s%0d", k), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
            7'((75 + k) % 100));
    end
    off2 = exp_off(1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("boundaryB", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, off2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("runB2_s1_accept", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'((off2 + 1) % 100));

    // Stop at s=40 with a pending symbol: finish the symbol, then drop it.
    for (int k = 2; k < 100; k++) begin
      step(1'b0, 1'b0, (k == 40), 1'b0, 1'b0);
      check($sformatf("runB2_s%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
            7'((off2 + k) % 100));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("stop_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("stop_restart_fill", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("pend_discarded", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'd0);
    end

    // Symbol 00, then reset mid-symbol and restart with fresh bits.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("fillC", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("firstC", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
    for (int k = 1; k <= 60; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("runC_s%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'(k));
    end
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("midrst_quiet", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("restart_first", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, off2);
    for (int k = 1; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("restart_s%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
            7'((off2 + k) % 100));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
